ram_async: RTL and testbench
============================

Name: ram_async

Overview:
- Small 32-word x 32-bit register-file style RAM with a single port.
- Writes are synchronous on the clock edge; reads are asynchronous (combinational from address to data_out).
- Used as a general-purpose scratch/data memory in the memory-types group of the design; drives no handshake.

Parameters:
- DATA_WIDTH, 32, width of each word and of data_in/data_out.
- ADDR_WIDTH, 5, width of address.
- DEPTH, 32, number of implemented words; legal range 1..2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- address  input  ADDR_WIDTH  word address for both read and write.
- writeOn  input  1  write enable; 1 = write data_in to address at next rising clk edge.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  read data; combinational function of address and current memory contents.

Behaviour:
- Storage: DEPTH words of DATA_WIDTH bits, implemented as flops (the reset must clear the whole array).
- Reset:
  - On a rising clk edge with rst=1, every word is cleared to 0; writeOn is ignored in that cycle (reset has priority).
  - After reset, data_out = 0 for every address.
  - Reset asserted mid-operation discards all prior contents.
- Write:
  - On a rising clk edge with rst=0 and writeOn=1 and address < DEPTH, mem[address] <= data_in.
  - Exactly one word is changed per cycle; all other words hold.
- Read:
  - data_out = mem[address] combinationally, with zero cycles of latency.
  - Changing address changes data_out within the same cycle; no clock is needed to read.
- Read during write (default build): before the edge, data_out shows the old contents of mem[address]. After the edge, it shows the newly written value, because the read reflects the updated array.
- Out-of-range (only possible when DEPTH < 2**ADDR_WIDTH):
  - Writes are ignored.
  - data_out = 0.
- Back-to-back writes to the same address: the last write wins.
- No X propagation: data_out is always a defined value after the first reset.
- Before the first reset, contents are unspecified.

Optional Feature:
- Macro: RAM_WRITE_THROUGH_EN.
- When defined: while writeOn=1, rst=0 and address < DEPTH, data_out = data_in combinationally (write-through bypass), so the value being written is visible in the same cycle before the edge. Otherwise data_out is as in the default build.
- When not defined: data_out always reflects the stored array contents (old data until the edge), as described in Behaviour.

Test Plan:
- Reset then read all 32 addresses with writeOn=0 -> data_out = 0x00000000 for each.
- Write 0xDEADBEEF to addr 3, then 0x12345678 to addr 31; read addr 3 and 31 -> 0xDEADBEEF and 0x12345678; addr 4 still reads 0.
- Drive addr 7, writeOn=1, data_in=0xA5A5A5A5:
  - Default build: data_out is 0 before the edge and 0xA5A5A5A5 after it.
  - With RAM_WRITE_THROUGH_EN: data_out is 0xA5A5A5A5 before the edge.
- Write addr 10 = 0x1 then addr 10 = 0x2 on consecutive cycles -> read addr 10 = 0x00000002.
- Assert rst=1 together with writeOn=1, addr 5, data 0xFFFFFFFF -> after the edge, addr 5 reads 0 and all previously written words read 0.
- Hold writeOn=0, change data_in randomly and step address 0..31 -> no contents change; data_out tracks address combinationally with no clock edge required.

Source files
------------

// File: rtl/ram_async.sv
// ram_async: flop-based RAM with synchronous write and combinational read.
// Define RAM_WRITE_THROUGH_EN to bypass data_in to data_out during a valid write.
module ram_async #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  writeOn,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic in_range;
   logic [DATA_WIDTH-1:0] stored;
   always_comb in_range = int'(address) < DEPTH;
   always_comb stored = in_range ? mem[address] : '0;
   always_ff @(posedge clk)
      if (rst)
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      else if (writeOn && in_range)
         mem[address] <= data_in;
`ifdef RAM_WRITE_THROUGH_EN
   always_comb data_out = (writeOn && !rst && in_range) ? data_in : stored;
`else
   always_comb data_out = stored;
`endif
endmodule

// File: tb/tb_ram_async.sv
// tb_ram_async: randomized and directed checks of ram_async against an array model.
module tb_ram_async;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  address;
   logic        writeOn;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic [31:0] model [32];
   int vectors = 0;
   int errs = 0;

   ram_async dut (
      .clk(clk), .rst(rst), .address(address), .writeOn(writeOn),
      .data_in(data_in), .data_out(data_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a;
      data_in = d;
      writeOn = 1'b1;
      #1;
`ifdef RAM_WRITE_THROUGH_EN
      chk("pre_edge_bypass", data_out, d);
`else
      chk("pre_edge_old", data_out, model[a]);
`endif
      @(posedge clk);
      model[a] = d;
      #1;
      writeOn = 1'b0;
      #1;
      chk("post_edge_new", data_out, d);
   endtask

   task automatic rd(input logic [4:0] a);
      writeOn = 1'b0;
      address = a;
      data_in = $urandom;
      #1;
      chk("read", data_out, model[a]);
   endtask

   task automatic do_reset(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      rst = 1'b1;
      writeOn = 1'b1;
      address = a;
      data_in = d;
      @(posedge clk);
      #1;
      rst = 1'b0;
      writeOn = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   initial begin
      rst = 1'b1;
      writeOn = 1'b0;
      address = '0;
      data_in = '0;
      do_reset(5'd0, 32'h0);
      for (int i = 0; i < 32; i++) rd(5'(i));
      wr(5'd3, 32'hDEADBEEF);
      wr(5'd31, 32'h12345678);
      rd(5'd3);
      chk("addr3_const", data_out, 32'hDEADBEEF);
      rd(5'd31);
      chk("addr31_const", data_out, 32'h12345678);
      rd(5'd4);
      chk("addr4_zero", data_out, 32'h0);
      wr(5'd7, 32'hA5A5A5A5);
      wr(5'd10, 32'h1);
      wr(5'd10, 32'h2);
      rd(5'd10);
      chk("last_write_wins", data_out, 32'h2);
      do_reset(5'd5, 32'hFFFFFFFF);
      rd(5'd5);
      chk("reset_beats_write", data_out, 32'h0);
      for (int i = 0; i < 32; i++) rd(5'(i));
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 1) == 1) wr(5'($urandom_range(0, 31)), $urandom);
         else rd(5'($urandom_range(0, 31)));
      end
      for (int i = 0; i < 32; i++) rd(5'(i));
      do_reset(5'($urandom_range(0, 31)), $urandom);
      for (int i = 0; i < 32; i++) rd(5'(i));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
